dp_executor: RTL and testbench



---
 rtl/dp_executor_if.sv | 24 ++
 rtl/dp_executor.sv | 203 ++++++++++++++++++++
 tb/tb_dp_executor.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_executor_if.sv
// Instruction handshake between an initiator FSM and dp_executor.
// Ports: start/instruction from initiator, finished/result back.
interface dp_executor_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [31:0]           instruction;
  logic                  finished;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start,
    output instruction,
    input  finished,
    input  result
  );

  modport slave (
    input  start,
    input  instruction,
    output finished,
    output result
  );
endinterface

// File: rtl/dp_executor.sv
// Datapath instruction executor: NOP, MEMREAD, MEMWRITE, DRAW.
// Ports: clock, resetn, cmd (slave handshake), RAM bus, VGA plot bus.
module dp_executor #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int DRAW_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  dp_executor_if.slave          cmd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [7:0]            vga_x,
  output logic [6:0]            vga_y,
  output logic [2:0]            vga_colour,
  output logic                  vga_plot
);

  localparam int CW =
    (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    RD_WAIT,
    RD_CAP,
    WR_DONE,
    DRAW_HOLD
  } state_t;

  state_t state, state_n;

  logic                  start_q;
  logic [31:0]           instr_q, instr_d;
  logic                  fin_q, fin_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wd_d;
  logic                  we_d;
  logic [7:0]            x_d;
  logic [6:0]            y_d;
  logic [2:0]            c_d;
  logic                  plot_d;
  logic [CW-1:0]         cnt, cnt_d;

  logic                  accept;
  logic                  op_nop, op_rd;
  logic                  op_wr, op_dr;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [DATA_WIDTH-1:0] f_wdata;

  // Only a fresh rising edge of start is taken, so the
  // initiator's second start cycle never re-triggers.
  assign accept  = cmd.start && !start_q;

  assign op_nop  = instr_q[3:0] == 4'd0;
  assign op_rd   = instr_q[3:0] == 4'd1;
  assign op_wr   = instr_q[3:0] == 4'd2;
  assign op_dr   = instr_q[3:0] == 4'd3;
  assign f_addr  = instr_q[4+ADDR_WIDTH-1:4];
  assign f_wdata = DATA_WIDTH'(instr_q[31:16]);

  assign cmd.finished = fin_q;
  assign cmd.result   = res_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) state_n = EXEC;
      end
      EXEC: begin
        unique case (1'b1)
          op_rd:   state_n = RD_WAIT;
          op_wr:   state_n = WR_DONE;
          op_dr:   state_n = DRAW_HOLD;
          default: state_n = IDLE;
        endcase
      end
      RD_WAIT: state_n = RD_CAP;
      RD_CAP:  state_n = IDLE;
      WR_DONE: state_n = IDLE;
      DRAW_HOLD: begin
        if (cnt == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    fin_d   = fin_q;
    res_d   = res_q;
    addr_d  = mem_addr;
    wd_d    = mem_wdata;
    we_d    = mem_we;
    x_d     = vga_x;
    y_d     = vga_y;
    c_d     = vga_colour;
    plot_d  = vga_plot;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          instr_d = cmd.instruction;
          fin_d   = 1'b0;
        end
      end
      EXEC: begin
        unique case (1'b1)
          op_rd: begin
            addr_d = f_addr;
          end
          op_wr: begin
            addr_d = f_addr;
            wd_d   = f_wdata;
            we_d   = 1'b1;
          end
          op_dr: begin
            x_d    = instr_q[11:4];
            y_d    = instr_q[18:12];
            c_d    = instr_q[21:19];
            plot_d = instr_q[22];
            cnt_d  = CW'(DRAW_CYCLES - 1);
          end
          op_nop: begin
            res_d = '0;
            fin_d = 1'b1;
          end
          default: begin
            res_d = '1;
            fin_d = 1'b1;
          end
        endcase
      end
      RD_WAIT: begin
      end
      RD_CAP: begin
        res_d = mem_rdata;
        fin_d = 1'b1;
      end
      WR_DONE: begin
        we_d  = 1'b0;
        res_d = f_wdata;
        fin_d = 1'b1;
      end
      DRAW_HOLD: begin
        if (cnt == '0) begin
          plot_d = 1'b0;
          res_d  = '0;
          fin_d  = 1'b1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // start_q resets high so a start held through reset
  // release is not mistaken for a rising edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      start_q    <= 1'b1;
      instr_q    <= '0;
      fin_q      <= 1'b1;
      res_q      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      cnt        <= '0;
    end else begin
      start_q    <= cmd.start;
      instr_q    <= instr_d;
      fin_q      <= fin_d;
      res_q      <= res_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wd_d;
      mem_we     <= we_d;
      vga_x      <= x_d;
      vga_y      <= y_d;
      vga_colour <= c_d;
      vga_plot   <= plot_d;
      cnt        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dp_executor.sv
// Scoreboard bench for dp_executor, two instances with
// DRAW_CYCLES=1 (A) and DRAW_CYCLES=3 (B) driven in lockstep.
module tb_dp_executor;

  typedef struct {
    string       name;
    logic [15:0] res;
    int          lat_a;
    int          lat_b;
    int          we_n;
    int          plot_a;
    int          plot_b;
    bit          ca;
    logic [11:0] addr;
    logic [15:0] wd;
    bit          cv;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
  } exp_t;

  logic clock;
  logic resetn;

  dp_executor_if #(.DATA_WIDTH(16)) ifa ();
  dp_executor_if #(.DATA_WIDTH(16)) ifb ();

  logic [11:0] a_addr, b_addr;
  logic [15:0] a_wd, b_wd, a_rd, b_rd;
  logic        a_we, b_we, a_plot, b_plot;
  logic [7:0]  a_x, b_x;
  logic [6:0]  a_y, b_y;
  logic [2:0]  a_c, b_c;

  logic [15:0] ram_a [4096];
  logic [15:0] ram_b [4096];

  exp_t qa[$];
  exp_t qb[$];

  int  checks   = 0;
  int  failures = 0;
  bit  mon_en   = 0;

  dp_executor #(
    .ADDR_WIDTH(12), .DATA_WIDTH(16), .DRAW_CYCLES(1)
  ) ua (
    .clock(clock), .resetn(resetn), .cmd(ifa),
    .mem_addr(a_addr), .mem_wdata(a_wd), .mem_we(a_we),
    .mem_rdata(a_rd), .vga_x(a_x), .vga_y(a_y),
    .vga_colour(a_c), .vga_plot(a_plot)
  );

  dp_executor #(
    .ADDR_WIDTH(12), .DATA_WIDTH(16), .DRAW_CYCLES(3)
  ) ub (
    .clock(clock), .resetn(resetn), .cmd(ifb),
    .mem_addr(b_addr), .mem_wdata(b_wd), .mem_we(b_we),
    .mem_rdata(b_rd), .vga_x(b_x), .vga_y(b_y),
    .vga_colour(b_c), .vga_plot(b_plot)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (a_we) ram_a[a_addr] <= a_wd;
    a_rd <= ram_a[a_addr];
    if (b_we) ram_b[b_addr] <= b_wd;
    b_rd <= ram_b[b_addr];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic done_chk(
    input exp_t e, input string s,
    input logic [15:0] res, input int lat,
    input int we, input int plot,
    input int lat_x, input int plot_x,
    input logic [11:0] addr, input logic [7:0] x,
    input logic [6:0] y, input logic [2:0] c);
    chk({e.name, s, "_result"}, 32'(res), 32'(e.res));
    chk({e.name, s, "_latency"}, lat, lat_x);
    chk({e.name, s, "_we_cycles"}, we, e.we_n);
    chk({e.name, s, "_plot_cycles"}, plot, plot_x);
    if (e.ca)
      chk({e.name, s, "_mem_addr"}, 32'(addr), 32'(e.addr));
    if (e.cv) begin
      chk({e.name, s, "_vga_x"}, 32'(x), 32'(e.x));
      chk({e.name, s, "_vga_y"}, 32'(y), 32'(e.y));
      chk({e.name, s, "_vga_c"}, 32'(c), 32'(e.c));
    end
  endtask

  int la, wa, pa, lb, wb, pb;
  bit pfa = 1, pfb = 1;

  always @(negedge clock) begin
    if (!mon_en) begin
      pfa = 1; la = 0; wa = 0; pa = 0;
    end else begin
      if (pfa && !ifa.finished && qa.size() == 0)
        chk("A_spurious_accept", 32'(ifa.finished), 1);
      if (!ifa.finished) begin
        la++;
        if (a_plot) pa++;
        if (a_we) begin
          wa++;
          if (qa.size() > 0) begin
            chk("A_we_addr", 32'(a_addr), 32'(qa[0].addr));
            chk("A_we_data", 32'(a_wd), 32'(qa[0].wd));
          end
        end
      end
      if (!pfa && ifa.finished) begin
        if (qa.size() == 0) begin
          chk("A_unexpected_done", qa.size(), 1);
        end else begin
          exp_t e;
          e = qa.pop_front();
          done_chk(e, "_A", ifa.result, la, wa, pa,
                   e.lat_a, e.plot_a, a_addr,
                   a_x, a_y, a_c);
        end
        la = 0; wa = 0; pa = 0;
      end
      pfa = ifa.finished;
    end
  end

  always @(negedge clock) begin
    if (!mon_en) begin
      pfb = 1; lb = 0; wb = 0; pb = 0;
    end else begin
      if (pfb && !ifb.finished && qb.size() == 0)
        chk("B_spurious_accept", 32'(ifb.finished), 1);
      if (!ifb.finished) begin
        lb++;
        if (b_plot) pb++;
        if (b_we) begin
          wb++;
          if (qb.size() > 0) begin
            chk("B_we_addr", 32'(b_addr), 32'(qb[0].addr));
            chk("B_we_data", 32'(b_wd), 32'(qb[0].wd));
          end
        end
      end
      if (!pfb && ifb.finished) begin
        if (qb.size() == 0) begin
          chk("B_unexpected_done", qb.size(), 1);
        end else begin
          exp_t e;
          e = qb.pop_front();
          done_chk(e, "_B", ifb.result, lb, wb, pb,
                   e.lat_b, e.plot_b, b_addr,
                   b_x, b_y, b_c);
        end
        lb = 0; wb = 0; pb = 0;
      end
      pfb = ifb.finished;
    end
  end

  function automatic exp_t mk(
    input string n, input logic [15:0] res,
    input int lta, input int ltb, input int we,
    input int pla, input int plb,
    input bit ca, input logic [11:0] ad,
    input logic [15:0] wd, input bit cv,
    input logic [7:0] x, input logic [6:0] y,
    input logic [2:0] c);
    exp_t e;
    e.name = n; e.res = res;
    e.lat_a = lta; e.lat_b = ltb; e.we_n = we;
    e.plot_a = pla; e.plot_b = plb;
    e.ca = ca; e.addr = ad; e.wd = wd;
    e.cv = cv; e.x = x; e.y = y; e.c = c;
    return e;
  endfunction

  task automatic drive(input logic s,
                       input logic [31:0] w);
    ifa.start = s; ifb.start = s;
    ifa.instruction = w; ifb.instruction = w;
  endtask

  // Initiator-style 2-cycle start; w2 is the word on the
  // second cycle and must never be executed.
  task automatic issue(input logic [31:0] w1,
                       input logic [31:0] w2,
                       input exp_t e);
    int n;
    qa.push_back(e);
    qb.push_back(e);
    drive(1'b1, w1);
    @(negedge clock);
    drive(1'b1, w2);
    @(negedge clock);
    drive(1'b0, w2);
    n = 0;
    while (!(ifa.finished && ifb.finished) && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20)
      chk({e.name, "_timeout"},
          32'(ifa.finished && ifb.finished), 1);
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    drive(1'b1, 32'h0040_0A03);
    repeat (3) @(negedge clock);
    chk("rst_finished_A", 32'(ifa.finished), 1);
    chk("rst_finished_B", 32'(ifb.finished), 1);
    chk("rst_result", 32'(ifa.result), 0);
    chk("rst_mem_addr", 32'(a_addr), 0);
    chk("rst_mem_wdata", 32'(a_wd), 0);
    chk("rst_mem_we", 32'(a_we), 0);
    chk("rst_vga", {a_x, a_y, a_c, a_plot}, 0);

    resetn = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("held_start_fin_A", 32'(ifa.finished), 1);
      chk("held_start_fin_B", 32'(ifb.finished), 1);
      chk("held_start_act",
          32'(a_we | a_plot | b_we | b_plot), 0);
    end
    drive(1'b0, 32'h0);
    @(negedge clock);
    mon_en = 1;

    issue(32'hBEEF_02A2, 32'hBEEF_02A2,
          mk("wr02A", 16'hBEEF, 2, 2, 1, 0, 0,
             1, 12'h02A, 16'hBEEF, 0, 0, 0, 0));
    issue(32'h1234_02A1, 32'h1234_02A1,
          mk("rd02A", 16'hBEEF, 3, 3, 0, 0, 0,
             1, 12'h02A, 0, 0, 0, 0, 0));
    issue(32'h0067_79F3, 32'h0067_79F3,
          mk("draw", 16'h0000, 2, 4, 0, 1, 3,
             1, 12'h02A, 0, 1, 8'd159, 7'd119, 3'd4));
    issue(32'h0010_50A3, 32'h0010_50A3,
          mk("draw_np", 16'h0000, 2, 4, 0, 0, 0,
             0, 0, 0, 1, 8'd10, 7'd5, 3'd2));
    issue(32'h0000_0000, 32'h0000_000F,
          mk("nop2cyc", 16'h0000, 1, 1, 0, 0, 0,
             0, 0, 0, 1, 8'd10, 7'd5, 3'd2));
    issue(32'h0000_000F, 32'h0000_000F,
          mk("illegalF", 16'hFFFF, 1, 1, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0));
    issue(32'hBEEF_02A4, 32'hBEEF_02A4,
          mk("illegal4", 16'hFFFF, 1, 1, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0));
    issue(32'h0001_FFF2, 32'h0001_FFF2,
          mk("wrFFF", 16'h0001, 2, 2, 1, 0, 0,
             1, 12'hFFF, 16'h0001, 0, 0, 0, 0));
    issue(32'h0000_FFF1, 32'h0000_FFF1,
          mk("rdFFF", 16'h0001, 3, 3, 0, 0, 0,
             1, 12'hFFF, 0, 0, 0, 0, 0));

    mon_en = 0;
    drive(1'b1, 32'h0000_02A1);
    @(negedge clock);
    @(negedge clock);
    drive(1'b0, 32'h0000_02A1);
    resetn = 0;
    @(negedge clock);
    chk("midrst_fin_A", 32'(ifa.finished), 1);
    chk("midrst_fin_B", 32'(ifb.finished), 1);
    chk("midrst_res_A", 32'(ifa.result), 0);
    chk("midrst_res_B", 32'(ifb.result), 0);
    resetn = 1;
    @(negedge clock);
    mon_en = 1;
    @(negedge clock);

    issue(32'h0000_02A1, 32'h0000_02A1,
          mk("rd_after_rst", 16'hBEEF, 3, 3, 0, 0, 0,
             1, 12'h02A, 0, 0, 0, 0, 0));

    repeat (3) @(negedge clock);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
